// File: rtl/if_prefetch_queue_if.sv
// Bundle between the prefetch queue and its neighbours: I-cache/BTB lookup, memory
// arbiter, cache fill and the ID-stage handshake. master = prefetch queue side.
interface if_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_hit;
    logic [INST_W-1:0] cache_val;
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_pred;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_done;
    logic [INST_W-1:0] mem_data;
    logic              fill_en;
    logic [ADDR_W-1:0] fill_addr;
    logic [INST_W-1:0] fill_data;
    // ID handshake: head transfers on a rising edge with out_valid && out_ready (and no flush);
    // out_valid never waits on out_ready, and out_* stay stable while valid and not accepted.
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_pred_taken;
    logic [ADDR_W-1:0] out_pred_target;
    logic [CNT_W-1:0]  count;
    logic [1:0]        dbg_state;  // 0 IDLE, 1 WAIT, 2 DRAIN

    modport master (
        input  flush, flush_pc, cache_hit, cache_val, btb_hit, btb_pred,
               mem_done, mem_data, out_ready,
        output cache_addr, mem_req, mem_addr, fill_en, fill_addr, fill_data,
               out_valid, out_pc, out_inst, out_pred_taken, out_pred_target,
               count, dbg_state
    );

    modport slave (
        output flush, flush_pc, cache_hit, cache_val, btb_hit, btb_pred,
               mem_done, mem_data, out_ready,
        input  cache_addr, mem_req, mem_addr, fill_en, fill_addr, fill_data,
               out_valid, out_pc, out_inst, out_pred_taken, out_pred_target,
               count, dbg_state
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Fetch unit running ahead of decode: fetches from I-cache or memory and buffers
// {pc, inst, pred_taken, pred_target} in a DEPTH-entry circular queue.
module if_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst,
    if_prefetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              fill_en_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [INST_W-1:0] fill_data_q;

    logic [ADDR_W-1:0] pc_q     [DEPTH];
    logic [INST_W-1:0] inst_q   [DEPTH];
    logic              taken_q  [DEPTH];
    logic [ADDR_W-1:0] target_q [DEPTH];

    logic              push, pop, full, head_valid, mem_ret;
    logic [ADDR_W-1:0] next_pc;
    logic [INST_W-1:0] push_inst;

    // Full is judged on registered count, so a same-cycle pop never frees a slot for a push.
    assign full       = (count_q == CNT_W'(DEPTH));
    assign head_valid = (count_q != '0);
    assign pop        = head_valid & bus.out_ready & ~bus.flush;
    assign next_pc    = bus.btb_hit ? bus.btb_pred : fetch_pc_q + ADDR_W'(4);
    assign mem_ret    = bus.mem_done & (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!bus.flush && !full && !bus.cache_hit) state_d = WAIT;
            WAIT:    if (bus.mem_done) state_d = IDLE;
                     else if (bus.flush) state_d = DRAIN;
            DRAIN:   if (bus.mem_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_inst = bus.cache_val;
        mem_req_d = mem_req_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.flush && !full) begin
                    if (bus.cache_hit) begin
                        push = 1'b1;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_q;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_done) begin
                    mem_req_d = 1'b0;
                    push      = ~bus.flush;
                    push_inst = bus.mem_data;
                end
            end
            DRAIN: begin
                // Data for a flushed-away request is only used to fill the cache.
                if (bus.mem_done) mem_req_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            fetch_pc_d = next_pc;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (bus.flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = bus.flush_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            fill_en_q   <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fill_en_q  <= mem_ret;
            if (mem_ret) begin
                fill_addr_q <= mem_addr_q;
                fill_data_q <= bus.mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_q]     <= fetch_pc_q;
            inst_q[wr_ptr_q]   <= push_inst;
            taken_q[wr_ptr_q]  <= bus.btb_hit;
            target_q[wr_ptr_q] <= next_pc;
        end
    end

    // Head fields are forced to zero when empty so uncleared storage never reaches ID.
    assign bus.out_valid       = head_valid;
    assign bus.out_pc          = head_valid ? pc_q[rd_ptr_q]     : '0;
    assign bus.out_inst        = head_valid ? inst_q[rd_ptr_q]   : '0;
    assign bus.out_pred_taken  = head_valid ? taken_q[rd_ptr_q]  : 1'b0;
    assign bus.out_pred_target = head_valid ? target_q[rd_ptr_q] : '0;
    assign bus.count           = count_q;
    assign bus.cache_addr      = fetch_pc_q;
    assign bus.mem_req         = mem_req_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.fill_en         = fill_en_q;
    assign bus.fill_addr       = fill_addr_q;
    assign bus.fill_data       = fill_data_q;
    assign bus.dbg_state       = state_q;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue: a queue-level reference model predicts every
// output each cycle; a directed tail covers asynchronous reset during a memory wait.
module tb_if_prefetch_queue;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int ENT_W  = ADDR_W + INST_W + 1 + ADDR_W;
    localparam int S_IDLE = 0, S_WAIT = 1, S_DRAIN = 2;

    logic clk;
    logic rst;

    if_prefetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) bus ();

    if_prefetch_queue #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [ENT_W-1:0]  exp_q[$];
    logic [ADDR_W-1:0] m_pc, m_addr, m_fill_addr;
    logic [INST_W-1:0] m_fill_data;
    logic              m_req, m_fill;
    int                m_mode;
    int                lat;
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc        = '0;
        m_addr      = '0;
        m_req       = 1'b0;
        m_fill      = 1'b0;
        m_fill_addr = '0;
        m_fill_data = '0;
        m_mode      = S_IDLE;
    endtask

    // Outcome of one rising edge, derived from the architectural rules on a plain queue.
    task automatic model_step();
        logic [ADDR_W-1:0] nxt;
        logic [ENT_W-1:0]  ent;
        logic              do_push, popping;
        nxt     = bus.btb_hit ? bus.btb_pred : m_pc + 32'd4;
        ent     = '0;
        do_push = 1'b0;
        popping = (exp_q.size() != 0) && bus.out_ready && !bus.flush;
        m_fill  = (m_mode != S_IDLE) && bus.mem_done;
        if (m_fill) begin
            m_fill_addr = m_addr;
            m_fill_data = bus.mem_data;
        end
        case (m_mode)
            S_IDLE: begin
                if (!bus.flush && exp_q.size() < DEPTH) begin
                    if (bus.cache_hit) begin
                        do_push = 1'b1;
                        ent     = {m_pc, bus.cache_val, bus.btb_hit, nxt};
                    end else begin
                        m_req  = 1'b1;
                        m_addr = m_pc;
                        m_mode = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_done) begin
                    m_req  = 1'b0;
                    m_mode = S_IDLE;
                    if (!bus.flush) begin
                        do_push = 1'b1;
                        ent     = {m_pc, bus.mem_data, bus.btb_hit, nxt};
                    end
                end else if (bus.flush) begin
                    m_mode = S_DRAIN;
                end
            end
            default: begin
                if (bus.mem_done) begin
                    m_req  = 1'b0;
                    m_mode = S_IDLE;
                end
            end
        endcase
        if (popping) void'(exp_q.pop_front());
        if (do_push) begin
            exp_q.push_back(ent);
            m_pc = nxt;
        end
        if (bus.flush) begin
            exp_q.delete();
            m_pc = bus.flush_pc;
        end
    endtask

    task automatic compare();
        check("out_valid", bus.out_valid, exp_q.size() != 0);
        check("count", bus.count, exp_q.size());
        if (exp_q.size() != 0)
            check("head", {bus.out_pc, bus.out_inst, bus.out_pred_taken, bus.out_pred_target}, exp_q[0]);
        check("cache_addr", bus.cache_addr, m_pc);
        check("mem_req", bus.mem_req, m_req);
        check("mem_addr", bus.mem_addr, m_addr);
        check("fill_en", bus.fill_en, m_fill);
        if (m_fill) begin
            check("fill_addr", bus.fill_addr, m_fill_addr);
            check("fill_data", bus.fill_data, m_fill_data);
        end
        check("state", bus.dbg_state, m_mode);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: check, then drive inputs for the next rising edge.
    task automatic step(input int hit_pct, input int ready_pct, input int btb_pct,
                        input int flush_pct, input bit flush_on_done);
        compare();
        if (bus.mem_done) begin
            bus.mem_done = 1'b0;
        end else if (bus.mem_req) begin
            if (lat == 0) begin
                bus.mem_done = 1'b1;
                bus.mem_data = $urandom;
                lat          = $urandom_range(0, 4);
            end else begin
                lat--;
            end
        end
        bus.cache_hit = ($urandom_range(0, 99) < hit_pct);
        bus.cache_val = $urandom;
        bus.btb_hit   = ($urandom_range(0, 99) < btb_pct);
        bus.btb_pred  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
        bus.out_ready = ($urandom_range(0, 99) < ready_pct);
        bus.flush     = ($urandom_range(0, 99) < flush_pct) ||
                        (flush_on_done && bus.mem_done && ($urandom_range(0, 1) == 1));
        bus.flush_pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
        model_step();
    endtask

    task automatic clear_inputs();
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;
        bus.cache_hit = 1'b0;
        bus.cache_val = '0;
        bus.btb_hit   = 1'b0;
        bus.btb_pred  = '0;
        bus.mem_done  = 1'b0;
        bus.mem_data  = '0;
        bus.out_ready = 1'b0;
    endtask

    // cycles, hit%, ready%, btb%, flush%, flush_on_done
    int phases[6][6] = '{
        '{ 40, 100, 100,  0, 0, 0},
        '{ 30, 100,   0,  0, 0, 0},
        '{ 30, 100, 100,  0, 0, 0},
        '{300,  70,  70, 30, 3, 0},
        '{300,  30,  50, 20, 5, 1},
        '{200,  90,  20, 40, 2, 1}
    };

    initial begin
        int budget;
        clear_inputs();
        model_reset();
        lat = $urandom_range(0, 4);
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        compare();
        check("rst_fill_addr", bus.fill_addr, 32'h0);
        check("rst_fill_data", bus.fill_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(100, 100, 0, 0, 0);

        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < phases[p][0]; c++) begin
                @(negedge clk);
                step(phases[p][1], phases[p][2], phases[p][3], phases[p][4], phases[p][5] != 0);
            end
        end

        // Steer into WAIT, then assert reset asynchronously between clock edges.
        budget = 0;
        while (!(m_mode == S_WAIT && !bus.mem_done) && budget < 200) begin
            @(negedge clk);
            step(0, 100, 0, 0, 0);
            budget++;
        end
        check("reach_wait", budget < 200, 1'b1);
        @(posedge clk);
        #2;
        check("mid_wait_req", bus.mem_req, m_req);
        rst = 1'b1;
        #1;
        check("async_mem_req", bus.mem_req, 1'b0);
        check("async_out_valid", bus.out_valid, 1'b0);
        check("async_count", bus.count, 3'd0);
        check("async_state", bus.dbg_state, S_IDLE);
        check("async_cache_addr", bus.cache_addr, 32'h0);
        clear_inputs();
        model_reset();
        lat = $urandom_range(0, 4);
        @(negedge clk);
        rst = 1'b0;
        step(100, 100, 0, 0, 0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            step(60, 80, 20, 3, 1);
        end
        @(negedge clk);
        compare();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised successor to the single-instruction IF stage: a fetch unit that runs ahead of decode and buffers fetched instructions in a DEPTH-entry queue.
- Each queue entry holds {pc, inst, pred_taken, pred_target}.
- Fetches come from the I-cache on a hit, or from memory through a req/done handshake on a miss. Memory returns fill the I-cache.
- Supports a BTB redirect per entry and flush-with-redirect, including a flush while a memory request is outstanding. Sits between PC/BTB/I-cache/memory arbiter and the ID stage.

Parameters:
- ADDR_W, 32, address width.
- INST_W, 32, instruction width.
- DEPTH, 4, queue entries; power of 2, ≥2.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous reset, active-high.
- flush in 1: discard queue, redirect fetch.
- flush_pc in ADDR_W: redirect target.
- cache_addr out ADDR_W: lookup address for I-cache and BTB (= fetch_pc, combinational).
- cache_hit in 1: I-cache hit for cache_addr.
- cache_val in INST_W: hit data.
- btb_hit in 1: BTB hit for cache_addr.
- btb_pred in ADDR_W: predicted target.
- mem_req out 1: memory fetch request, level.
- mem_addr out ADDR_W: request address.
- mem_done in 1: one-cycle completion pulse.
- mem_data in INST_W: data, valid with mem_done.
- fill_en out 1: I-cache fill strobe.
- fill_addr out ADDR_W: fill address.
- fill_data out INST_W: fill data.
- out_valid out 1: queue head valid.
- out_ready in 1: ID accepts head.
- out_pc out ADDR_W: head pc.
- out_inst out INST_W: head instruction.
- out_pred_taken out 1: head BTB prediction.
- out_pred_target out ADDR_W: head next-pc prediction.
- count out clog2(DEPTH)+1: occupancy.

Behaviour:
- Reset (async, takes effect immediately):
  - fetch_pc=RESET_PC, state=IDLE, rd_ptr=wr_ptr=count=0.
  - mem_req=0, mem_addr=0, fill_en=0, fill_addr=0, fill_data=0, out_valid=0.
  - Entry storage need not be cleared. Reset mid-request abandons the request; memory owns the recovery.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE, no flush, count<DEPTH:
  - cache_hit=1: push {fetch_pc, cache_val, btb_hit, btb_hit?btb_pred:fetch_pc+4}; fetch_pc<=that next-pc. Throughput 1 inst/cycle.
  - cache_hit=0: mem_req<=1, mem_addr<=fetch_pc, →WAIT.
- IDLE with count==DEPTH: no push and no request. This holds even if a pop happens the same cycle; push is gated on registered count.
- WAIT:
  - mem_req held 1 until mem_done.
  - On mem_done: push {fetch_pc, mem_data, btb_hit, next-pc} using BTB inputs sampled that cycle; fetch_pc advances; mem_req<=0; →IDLE.
  - Space is guaranteed because only pops occur while in WAIT.
- Fill: every mem_done (WAIT or DRAIN) gives fill_en=1 for exactly one cycle, registered, the cycle after mem_done, with fill_addr=mem_addr and fill_data=mem_data.
- Flush (highest priority; overrides push and pop that cycle):
  - rd_ptr=wr_ptr=count<=0, fetch_pc<=flush_pc.
  - In WAIT without same-cycle mem_done: →DRAIN, mem_req stays 1.
  - In WAIT with same-cycle mem_done: data discarded (no push), fill still occurs, →IDLE.
  - In DRAIN: fetch_pc updated again; state unchanged.
- DRAIN: wait for mem_done; discard data (no push), fill occurs, mem_req<=0, →IDLE.
- Output:
  - out_valid=(count!=0); out_* driven combinationally from the rd_ptr entry.
  - Pop when out_valid&&out_ready&&!flush.
  - Push and pop in the same cycle leaves count unchanged.
- Pointers wrap modulo DEPTH.
- fetch_pc+4 wraps modulo 2^ADDR_W.
- No X on outputs after reset.

Test Plan (DEPTH=4, RESET_PC=0):
1. All hits, no BTB hit, out_ready=1, reset released → first out_valid one cycle later with out_pc=0x0; then 0x4, 0x8, 0xC on consecutive cycles; mem_req stays 0.
2. All hits, out_ready=0 → count reaches 4 after 4 cycles, cache_addr holds 0x10, no further push. Raise out_ready → pcs 0x0, 0x4, 0x8, 0xC, then 0x10 in order.
3. Miss at 0x8 → mem_req=1 with mem_addr=0x8 on the next cycle. mem_done 3 cycles later with data 0x00A00093 → entry pc 0x8 / inst 0x00A00093 queued; fill_en one-cycle pulse with fill_addr=0x8; mem_req=0 after.
4. btb_hit=1, btb_pred=0x40 at pc 0x4 → entry pc 0x4 has out_pred_taken=1 and out_pred_target=0x40; next entry pc=0x40.
5. flush with flush_pc=0x100 while WAIT on 0x8 → next cycle count=0, out_valid=0, state DRAIN. On mem_done: no push, fill_addr=0x8. Next fetch is at 0x100.
6. Flush and mem_done in the same cycle; separately, rst asserted mid-WAIT → first case: no push, state IDLE, fetch_pc=flush_pc. Second case: mem_req=0, out_valid=0, count=0 immediately (before the next clk edge), fetch resumes at 0x0.
